aes_sched: RTL and testbench
============================

# aes_sched

Two-requester scheduler in front of `aes_top`. It arbitrates block-encryption requests from two channels, each with its own key. It issues the `en`/`aes_key_strobe` pulse, requesting key re-expansion only when the active key changes. It holds the shared `aes_top` operands stable, captures the ciphertext into a one-entry tagged output buffer, and flags a sticky error if the core never completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum cycles in WAIT before abort; legal range 2..255.

Ports (`KEY_S` = `BLK_S` = 128, from `aes.vh`):
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `key_wr`  in  2  per-channel key write strobe; bit i targets channel i.
- `key_in0`, `key_in1`  in  `KEY_S` each  channel key data, sampled when the matching `key_wr` bit is high.
- `req_valid`  in  2  per-channel request valid.
- `req_ready`  out  2  per-channel accept, one-hot or zero.
- `req_data0`, `req_data1`  in  `BLK_S` each  plaintext.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `res_data`  out  `BLK_S`  ciphertext.
- `res_ch`  out  1  channel the result belongs to.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.
- `aes_en`, `aes_key_strobe`  out  1  drive `aes_top` `en`/`aes_key_strobe`.
- `aes_key`  out  `KEY_S`  drives `aes_top` `aes_key`.
- `aes_plaintext`  out  `BLK_S`  drives `aes_top` `aes_plaintext`.
- `aes_ciphertext`  in  `BLK_S`  from `aes_top`.
- `aes_en_o`  in  1  `aes_top` completion pulse.

## Operation
- Per-channel state: `key_reg[i]`, `key_dirty[i]`.
  - `key_wr[i]` loads `key_reg[i]` and sets `key_dirty[i]`; this is legal in any state.
- Core key tracking: `loaded_vld`, `loaded_ch`.
  - Re-expansion is needed when `!loaded_vld`, when `loaded_ch` differs from the granted channel, or when `key_dirty` of the granted channel is set.
- FSM: IDLE, ISSUE, WAIT.
  - IDLE: if `res_valid==0` (or `res_valid && res_ready` this cycle), arbitrate among `req_valid`, assert `req_ready` for the winner, and latch `cur_ch`, `cur_pt`, `cur_key`. Latch the need flag as `cur_strobe`, clear the winner's `key_dirty` (unless `key_wr` hits it the same cycle, in which case dirty stays set and the new key is latched). Go to ISSUE.
  - ISSUE (1 cycle): `aes_en=1`, `aes_key_strobe=cur_strobe`. Set `loaded_ch=cur_ch`, `loaded_vld=1`. Go to WAIT.
  - WAIT: `aes_en=0`. On `aes_en_o`, load `res_data=aes_ciphertext`, set `res_ch=cur_ch`, set `res_valid=1`, then go to IDLE. If the timeout counter reaches `TIMEOUT_CYCLES`: set `err`, clear `loaded_vld`, drop the block (no result), go to IDLE.
- `aes_key`/`aes_plaintext` come from `cur_key`/`cur_pt` and are held constant from ISSUE through WAIT exit.
- Arbitration: 2-way round-robin. The pointer is the last granted channel and updates only on grant. Reset pointer is 1, so channel 0 wins first.
- `res_valid` clears on `res_valid && res_ready`.
- `err`: set has priority over `err_clr` in the same cycle.
- `aes_en_o` outside WAIT is ignored.

## Timing
- Reset values:
  - outputs: `req_ready=0`, `res_valid=0`, `res_data=0`, `res_ch=0`, `err=0`, `aes_en=0`, `aes_key_strobe=0`, `aes_key=0`, `aes_plaintext=0`.
  - internal: state IDLE, `loaded_vld=0`, both `key_dirty=0`, `key_reg=0`.
- Accept at cycle T → `aes_en` high at T+1 → `res_valid` high the cycle after `aes_en_o` is sampled.
- `req_ready` is combinational from IDLE and the `req_valid`/buffer status; it is never high outside IDLE. At most one request is in flight.
- Back-to-back: a result popped in cycle T allows a grant in the same cycle T.
- Timeout counter: cleared in ISSUE, incremented each WAIT cycle. Abort occurs when the count equals `TIMEOUT_CYCLES` without `aes_en_o`. If `aes_en_o` arrives in that same cycle, completion wins.
- Reset mid-WAIT aborts the block, invalidates the loaded key, and discards channel keys.

## Structure
- Add to `aes.vh`: FSM state encodings `SCHED_IDLE`/`SCHED_ISSUE`/`SCHED_WAIT` (2 bits) and the timeout counter width (8).
- Sub-module `aes_rr_arb2`: 2-request round-robin arbiter with a grant-enable input, a one-hot grant output, and an internal pointer.
- Top-level integration instantiates `aes_sched` and `aes_top` side by side.

## Test plan
- Reset release, ch0 key `000102…0f`, plaintext `00112233445566778899aabbccddeeff` → one `aes_en` with `aes_key_strobe=1`; `res_data=69c4e0d86a7b0430d8cdb78070b4c55a`, `res_ch=0`.
- Second ch0 request with the same plaintext → `aes_key_strobe=0`; same ciphertext.
- Ch1 key `2b7e151628aed2a6abf7158809cf4f3c`, both channels requesting continuously → grants alternate 1,0,1,0. Every grant re-strobes. Ch1 ciphertext for plaintext `3243f6a8885a308d313198a2e0370734` is `3925841d02dc09fbdc118597196a0b32`.
- Hold `res_ready=0` with a result pending → `req_ready` stays 0 on both channels. `res_data`/`res_ch` are stable until the pop.
- `key_wr[0]` to a new key while a ch0 block is in WAIT → the in-flight result uses the old key. The next ch0 request strobes and uses the new key.
- Stub core that never pulses `aes_en_o`, `TIMEOUT_CYCLES=8` → `err=1` after 8 WAIT cycles, no `res_valid`. The next request strobes. `err_clr` returns `err` to 0.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared definitions for the two-channel AES request scheduler.
//   KEY_S / BLK_S     : key and block widths of the aes_top core
//   TMO_W             : width of the WAIT-state timeout counter
//   sched_state_t     : scheduler FSM encoding (IDLE / ISSUE / WAIT)
//   need_rekey()      : decides whether the core must re-expand its key
package aes_sched_pkg;

    localparam int KEY_S = 128;
    localparam int BLK_S = 128;
    localparam int TMO_W = 8;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_WAIT  = 2'd2
    } sched_state_t;

    // The expanded key inside the core can be reused only if it is known
    // valid, belongs to the same channel and that channel's key has not
    // been rewritten since it was last expanded.
    function automatic logic need_rekey(
        input logic loaded_vld,
        input logic loaded_ch,
        input logic grant_ch,
        input logic grant_dirty
    );
        return (!loaded_vld) || (loaded_ch != grant_ch) || grant_dirty;
    endfunction

endpackage

// File: rtl/aes_sched_if.sv
// aes_sched_if: requester-side bundle of the scheduler.
//   key_wr/key_in0/key_in1      : per-channel key load
//   req_valid/req_ready/req_data: per-channel block requests
//   res_valid/res_ready/res_data/res_ch : tagged result buffer
//   err/err_clr                 : sticky timeout flag and its clear
// master = requesters/consumer side, slave = scheduler side.
interface aes_sched_if;
    import aes_sched_pkg::*;

    logic [1:0]       key_wr;
    logic [KEY_S-1:0] key_in0;
    logic [KEY_S-1:0] key_in1;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [BLK_S-1:0] req_data0;
    logic [BLK_S-1:0] req_data1;
    logic             res_valid;
    logic             res_ready;
    logic [BLK_S-1:0] res_data;
    logic             res_ch;
    logic             err;
    logic             err_clr;

    modport master (
        output key_wr, key_in0, key_in1,
        output req_valid, req_data0, req_data1,
        output res_ready, err_clr,
        input  req_ready, res_valid, res_data, res_ch, err
    );

    modport slave (
        input  key_wr, key_in0, key_in1,
        input  req_valid, req_data0, req_data1,
        input  res_ready, err_clr,
        output req_ready, res_valid, res_data, res_ch, err
    );

endinterface

// File: rtl/aes_sched_arb.sv
// aes_rr_arb2: two-request round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   i_req      : request vector
//   i_gnt_en   : grants are only issued while this is high
//   o_gnt      : one-hot (or zero) grant, combinational
// The pointer remembers the last granted channel and moves only on a
// grant; it resets to 1 so channel 0 wins the first contention.
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_gnt_en,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // Grant selection: on contention, the channel not served last wins.
    always_comb begin
        o_gnt = 2'b00;
        if (!i_gnt_en) begin
            o_gnt = 2'b00;
        end else if (i_req == 2'b11) begin
            o_gnt = r_ptr ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

    // Last-granted pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b1;
        end else if (o_gnt != 2'b00) begin
            r_ptr <= o_gnt[1];
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/aes_sched.sv
// aes_sched: two-channel scheduler in front of an aes_top core.
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : per-channel keys/requests, tagged result buffer, err
//   aes_en          : one-cycle start pulse to the core
//   aes_key_strobe  : asks the core to re-expand aes_key with this start
//   aes_key         : key operand, held from ISSUE until WAIT exits
//   aes_plaintext   : block operand, held from ISSUE until WAIT exits
//   aes_ciphertext  : core result
//   aes_en_o        : core completion pulse (honoured only in WAIT)
// At most one block is in flight.  A grant needs an empty result buffer
// or one that is being popped in the same cycle.
module aes_sched
    import aes_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    aes_sched_if.slave       bus,
    output logic             aes_en,
    output logic             aes_key_strobe,
    output logic [KEY_S-1:0] aes_key,
    output logic [BLK_S-1:0] aes_plaintext,
    input  logic [BLK_S-1:0] aes_ciphertext,
    input  logic             aes_en_o
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;

    logic [KEY_S-1:0] r_key0;
    logic [KEY_S-1:0] r_key1;
    logic [1:0]       r_key_dirty;
    logic             r_loaded_vld;
    logic             r_loaded_ch;

    logic             r_cur_ch;
    logic [BLK_S-1:0] r_cur_pt;
    logic [KEY_S-1:0] r_cur_key;
    logic             r_aes_en;
    logic             r_aes_key_strobe;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic             r_res_valid;
    logic [BLK_S-1:0] r_res_data;
    logic             r_res_ch;
    logic             r_err;

    logic             w_buf_free;
    logic             w_pop;
    logic             w_gnt_en;
    logic [1:0]       w_gnt;
    logic             w_grant;
    logic             w_gnt_ch;
    logic             w_need;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic             w_done;
    logic             w_abort;

    aes_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (bus.req_valid),
        .i_gnt_en (w_gnt_en),
        .o_gnt    (w_gnt)
    );

    // Grant qualification, re-key decision and WAIT exit conditions.
    always_comb begin
        w_pop     = r_res_valid & bus.res_ready;
        w_buf_free = (~r_res_valid) | bus.res_ready;
        w_gnt_en  = (r_state == SCHED_IDLE) & w_buf_free;
        w_grant   = (w_gnt != 2'b00);
        w_gnt_ch  = w_gnt[1];
        w_need    = need_rekey(r_loaded_vld, r_loaded_ch, w_gnt_ch,
                               r_key_dirty[w_gnt_ch]);
        w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        w_done    = (r_state == SCHED_WAIT) & aes_en_o;
        // Completion in the final allowed cycle beats the abort.
        w_abort   = (r_state == SCHED_WAIT) & (~aes_en_o) &
                    (w_tmo_nxt == TMO_LIMIT);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCHED_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = SCHED_ISSUE;
                end else begin
                    w_state_nxt = SCHED_IDLE;
                end
            end
            SCHED_ISSUE: begin
                w_state_nxt = SCHED_WAIT;
            end
            SCHED_WAIT: begin
                if (w_done || w_abort) begin
                    w_state_nxt = SCHED_IDLE;
                end else begin
                    w_state_nxt = SCHED_WAIT;
                end
            end
            default: begin
                w_state_nxt = SCHED_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SCHED_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Channel key storage; a write on the granted channel keeps it dirty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key0      <= {KEY_S{1'b0}};
            r_key1      <= {KEY_S{1'b0}};
            r_key_dirty <= 2'b00;
        end else begin
            if (bus.key_wr[0]) begin
                r_key0         <= bus.key_in0;
                r_key_dirty[0] <= 1'b1;
            end else if (w_grant && !w_gnt_ch) begin
                r_key_dirty[0] <= 1'b0;
            end else begin
                r_key_dirty[0] <= r_key_dirty[0];
            end
            if (bus.key_wr[1]) begin
                r_key1         <= bus.key_in1;
                r_key_dirty[1] <= 1'b1;
            end else if (w_grant && w_gnt_ch) begin
                r_key_dirty[1] <= 1'b0;
            end else begin
                r_key_dirty[1] <= r_key_dirty[1];
            end
        end
    end

    // Operand capture on grant; the pre-write key is the one used.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_ch  <= 1'b0;
            r_cur_pt  <= {BLK_S{1'b0}};
            r_cur_key <= {KEY_S{1'b0}};
        end else if (w_grant) begin
            r_cur_ch  <= w_gnt_ch;
            r_cur_pt  <= w_gnt_ch ? bus.req_data1 : bus.req_data0;
            r_cur_key <= w_gnt_ch ? r_key1 : r_key0;
        end else begin
            r_cur_ch  <= r_cur_ch;
            r_cur_pt  <= r_cur_pt;
            r_cur_key <= r_cur_key;
        end
    end

    // Start pulse and key strobe, high for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aes_en         <= 1'b0;
            r_aes_key_strobe <= 1'b0;
        end else begin
            r_aes_en         <= w_grant;
            r_aes_key_strobe <= w_grant & w_need;
        end
    end

    // Tracks which channel's key the core currently holds expanded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_loaded_vld <= 1'b0;
            r_loaded_ch  <= 1'b0;
        end else if (r_state == SCHED_ISSUE) begin
            r_loaded_vld <= 1'b1;
            r_loaded_ch  <= r_cur_ch;
        end else if (w_abort) begin
            // A core that never finished may hold a half-expanded key.
            r_loaded_vld <= 1'b0;
            r_loaded_ch  <= r_loaded_ch;
        end else begin
            r_loaded_vld <= r_loaded_vld;
            r_loaded_ch  <= r_loaded_ch;
        end
    end

    // WAIT-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (r_state == SCHED_ISSUE) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (r_state == SCHED_WAIT) begin
            r_tmo_cnt <= w_tmo_nxt;
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    // One-entry tagged result buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_data  <= {BLK_S{1'b0}};
            r_res_ch    <= 1'b0;
        end else if (w_done) begin
            r_res_valid <= 1'b1;
            r_res_data  <= aes_ciphertext;
            r_res_ch    <= r_cur_ch;
        end else if (w_pop) begin
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= r_res_valid;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

    assign bus.req_ready   = w_gnt;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_ch      = r_res_ch;
    assign bus.err         = r_err;
    assign aes_en          = r_aes_en;
    assign aes_key_strobe  = r_aes_key_strobe;
    assign aes_key         = r_cur_key;
    assign aes_plaintext   = r_cur_pt;

endmodule

// File: tb/tb_aes_sched.sv
// tb_aes_sched: self-checking bench for aes_sched.
// A behavioural stub stands in for aes_top: it re-expands (stores) the key
// only when strobed and answers after a programmable latency (0 = never).
// Known test vectors return real AES ciphertexts, other pairs a keyed mix.
// A transaction-level reference model predicts grants, strobes, operands,
// results and err from the scheduling rules.
module tb_aes_sched;
    import aes_sched_pkg::*;

    localparam int TMO = 8;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KN = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         clk = 1'b0;
    logic         reset;
    logic         aes_en, aes_key_strobe, aes_en_o;
    logic [127:0] aes_key, aes_plaintext, aes_ciphertext;

    always #5 clk = ~clk;

    aes_sched_if bus();

    aes_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .aes_en         (aes_en),
        .aes_key_strobe (aes_key_strobe),
        .aes_key        (aes_key),
        .aes_plaintext  (aes_plaintext),
        .aes_ciphertext (aes_ciphertext),
        .aes_en_o       (aes_en_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model
    logic [127:0] m_key [2];
    bit           m_dirty [2];
    bit           m_lvld, m_lch, m_last;
    bit           m_inflight, m_issue;
    int           m_wait;
    bit           m_cur_ch, m_cur_strobe;
    logic [127:0] m_cur_key, m_cur_pt;
    bit           m_resv, m_resch, m_err;
    logic [127:0] m_resd;

    // core stub
    logic [127:0] s_key = 128'h0;
    logic [127:0] s_ct  = 128'h0;
    bit           s_busy = 1'b0;
    int           s_left = 0;
    int           s_lat  = 0;
    int           core_lat = 1;
    bit           stray = 1'b0;

    // last observed cycle
    logic [1:0]   last_rdy;
    bit           last_en, last_strobe;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] f_enc(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return C0;
        if (k == K1 && p == P1) return C1;
        return p ^ k ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_3c3c_c3c3_0ff0_f00f_1234_8765;
    endfunction

    task automatic model_reset();
        m_key[0] = 128'h0; m_key[1] = 128'h0;
        m_dirty[0] = 1'b0; m_dirty[1] = 1'b0;
        m_lvld = 1'b0; m_lch = 1'b0; m_last = 1'b1;
        m_inflight = 1'b0; m_issue = 1'b0; m_wait = 0;
        m_cur_ch = 1'b0; m_cur_strobe = 1'b0; m_cur_key = 128'h0; m_cur_pt = 128'h0;
        m_resv = 1'b0; m_resch = 1'b0; m_err = 1'b0; m_resd = 128'h0;
    endtask

    // One clock: drive the stub, compare everything, advance model and stub.
    task automatic step();
        logic [1:0] exp_rdy;
        bit         fire, gch, err_set;
        fire = s_busy && (s_lat != 0) && (s_left == 1);
        aes_en_o = fire || (stray && !m_inflight);
        aes_ciphertext = (stray && !m_inflight && !fire) ? {$urandom, $urandom, $urandom, $urandom} : s_ct;
        #1;
        chk("aes_en", aes_en, m_issue);
        if (m_issue) begin
            chk("strobe", aes_key_strobe, m_cur_strobe);
            chk("aes_key", aes_key, m_cur_key);
            chk("aes_pt", aes_plaintext, m_cur_pt);
        end else if (m_inflight) begin
            chk("key_held", aes_key, m_cur_key);
            chk("pt_held", aes_plaintext, m_cur_pt);
        end
        chk("res_valid", bus.res_valid, m_resv);
        if (m_resv) begin
            chk("res_data", bus.res_data, m_resd);
            chk("res_ch", bus.res_ch, m_resch);
        end
        chk("err", bus.err, m_err);
        exp_rdy = 2'b00;
        if (!m_inflight && (!m_resv || bus.res_ready)) begin
            if (bus.req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
            else exp_rdy = bus.req_valid;
        end
        chk("req_ready", bus.req_ready, exp_rdy);
        last_rdy = bus.req_ready; last_en = aes_en; last_strobe = aes_key_strobe;

        // scheduling rules
        err_set = 1'b0;
        if (m_resv && bus.res_ready) m_resv = 1'b0;
        if (m_inflight && !m_issue) begin
            m_wait++;
            if (aes_en_o) begin
                m_resv = 1'b1; m_resd = f_enc(m_cur_key, m_cur_pt); m_resch = m_cur_ch;
                m_inflight = 1'b0;
            end else if (m_wait == TMO) begin
                err_set = 1'b1; m_lvld = 1'b0; m_inflight = 1'b0;
            end
        end
        if (err_set) m_err = 1'b1;
        else if (bus.err_clr) m_err = 1'b0;
        if (m_issue) begin
            m_lvld = 1'b1; m_lch = m_cur_ch; m_issue = 1'b0; m_wait = 0;
        end
        if (exp_rdy != 2'b00) begin
            gch = exp_rdy[1];
            m_cur_ch = gch;
            m_cur_pt = gch ? bus.req_data1 : bus.req_data0;
            m_cur_key = m_key[gch];
            m_cur_strobe = !m_lvld || (m_lch != gch) || m_dirty[gch];
            m_dirty[gch] = 1'b0;
            m_last = gch; m_inflight = 1'b1; m_issue = 1'b1;
        end
        if (bus.key_wr[0]) begin m_key[0] = bus.key_in0; m_dirty[0] = 1'b1; end
        if (bus.key_wr[1]) begin m_key[1] = bus.key_in1; m_dirty[1] = 1'b1; end

        // stub core
        if (aes_en) begin
            if (aes_key_strobe) s_key = aes_key;
            s_ct = f_enc(s_key, aes_plaintext);
            s_busy = 1'b1; s_left = core_lat; s_lat = core_lat;
        end else if (s_busy) begin
            if (fire) s_busy = 1'b0;
            s_left--;
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        bus.key_wr = 2'b00; bus.key_in0 = 128'h0; bus.key_in1 = 128'h0;
        bus.req_valid = 2'b00; bus.req_data0 = 128'h0; bus.req_data1 = 128'h0;
        bus.res_ready = 1'b0; bus.err_clr = 1'b0;
        aes_en_o = 1'b0; aes_ciphertext = 128'h0; stray = 1'b0; s_busy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_data", bus.res_data, 128'h0);
        chk("rst_res_ch", bus.res_ch, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_aes_en", aes_en, 1'b0);
        chk("rst_strobe", aes_key_strobe, 1'b0);
        chk("rst_aes_key", aes_key, 128'h0);
        chk("rst_aes_pt", aes_plaintext, 128'h0);
        reset = 1'b0;
    endtask

    task automatic wr_key(input bit ch, input logic [127:0] k);
        bus.key_wr = ch ? 2'b10 : 2'b01;
        if (ch) bus.key_in1 = k; else bus.key_in0 = k;
        step();
        bus.key_wr = 2'b00;
    endtask

    // Issue one request and pop its result; reports what was observed.
    task automatic txn(input bit ch, input logic [127:0] pt, input int lat,
                       output logic got_strobe, output logic [127:0] got_ct, output logic got_ch);
        bit granted, seen;
        core_lat = lat; bus.res_ready = 1'b0;
        bus.req_valid = ch ? 2'b10 : 2'b01;
        if (ch) bus.req_data1 = pt; else bus.req_data0 = pt;
        got_strobe = 1'b0; got_ct = 128'h0; got_ch = 1'b0; granted = 1'b0; seen = 1'b0;
        for (int g = 0; g < 60 && !seen; g++) begin
            if (bus.res_valid && granted) begin
                got_ct = bus.res_data; got_ch = bus.res_ch; bus.res_ready = 1'b1; seen = 1'b1;
            end
            step();
            if (last_rdy != 2'b00) begin granted = 1'b1; bus.req_valid = 2'b00; end
            if (last_en) got_strobe = last_strobe;
        end
        bus.res_ready = 1'b0; bus.req_valid = 2'b00;
        chk("txn_complete", seen, 1'b1);
    endtask

    typedef struct {
        bit           ch;
        bit           wr;
        logic [127:0] key;
        logic [127:0] pt;
        bit           exp_strobe;
        logic [127:0] exp_ct;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t         tbl [6];
        logic         gs, gch;
        logic [127:0] gct, held;
        int           cnt;
        bit           grants [$];
        bit           exp_alt [4];

        tbl[0] = '{1'b0, 1'b1, K0, P0, 1'b1, C0};
        tbl[1] = '{1'b0, 1'b0, K0, P0, 1'b0, C0};
        tbl[2] = '{1'b1, 1'b1, K1, P1, 1'b1, C1};
        tbl[3] = '{1'b0, 1'b0, K0, P0, 1'b1, C0};
        tbl[4] = '{1'b1, 1'b0, K1, P1, 1'b1, C1};
        tbl[5] = '{1'b1, 1'b0, K1, P1, 1'b0, C1};
        exp_alt[0] = 1'b0; exp_alt[1] = 1'b1; exp_alt[2] = 1'b0; exp_alt[3] = 1'b1;

        reset_dut();

        // directed vectors
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].wr) wr_key(tbl[i].ch, tbl[i].key);
            txn(tbl[i].ch, tbl[i].pt, 3, gs, gct, gch);
            chk($sformatf("vec%0d_strobe", i), gs, tbl[i].exp_strobe);
            chk($sformatf("vec%0d_ct", i), gct, tbl[i].exp_ct);
            chk($sformatf("vec%0d_ch", i), gch, tbl[i].ch);
        end

        // both channels requesting: grants alternate, last grant was ch1
        bus.req_data0 = P0; bus.req_data1 = P1; bus.req_valid = 2'b11;
        bus.res_ready = 1'b1; core_lat = 1;
        for (int g = 0; g < 40 && grants.size() < 4; g++) begin
            step();
            if (last_rdy != 2'b00) grants.push_back(last_rdy[1]);
        end
        bus.req_valid = 2'b00;
        chk("alt_count", 128'(grants.size()), 128'(4));
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk($sformatf("alt_grant%0d", i), grants[i], exp_alt[i]);
        repeat (6) step();
        bus.res_ready = 1'b0;

        // result pending with res_ready low blocks all grants
        bus.req_valid = 2'b01; core_lat = 2;
        cnt = 0;
        while (!bus.res_valid && cnt < 30) begin
            step();
            if (last_rdy != 2'b00) bus.req_valid = 2'b00;
            cnt++;
        end
        chk("hold_result", bus.res_valid, 1'b1);
        held = bus.res_data;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_no_grant", last_rdy, 2'b00);
            chk("hold_data", bus.res_data, held);
        end
        bus.req_valid = 2'b00; bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;

        // ch0 key rewritten while its block is in WAIT
        wr_key(1'b0, K0);
        txn(1'b0, P0, 2, gs, gct, gch);
        bus.req_valid = 2'b01; bus.req_data0 = P0; core_lat = 6;
        cnt = 0;
        do begin step(); cnt++; end while (!last_en && cnt < 20);
        bus.req_valid = 2'b00;
        step();
        wr_key(1'b0, KN);
        cnt = 0;
        while (!bus.res_valid && cnt < 30) begin step(); cnt++; end
        chk("inflight_old_key", bus.res_data, C0);
        bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
        txn(1'b0, P0, 2, gs, gct, gch);
        chk("newkey_strobe", gs, 1'b1);
        chk("newkey_ct", gct, f_enc(KN, P0));

        // core never answers: abort after TMO WAIT cycles
        bus.req_valid = 2'b10; bus.req_data1 = P1; core_lat = 0;
        cnt = 0;
        do begin step(); cnt++; end while (!last_en && cnt < 20);
        bus.req_valid = 2'b00;
        cnt = 0;
        while (!bus.err && cnt < 30) begin step(); cnt++; end
        chk("tmo_wait_cycles", 128'(cnt), 128'(TMO));
        chk("tmo_no_result", bus.res_valid, 1'b0);
        // completion in the last allowed cycle wins; key was invalidated
        txn(1'b1, P1, TMO, gs, gct, gch);
        chk("tmo_edge_strobe", gs, 1'b1);
        chk("tmo_edge_ct", gct, C1);
        chk("err_sticky", bus.err, 1'b1);
        bus.err_clr = 1'b1; step(); bus.err_clr = 1'b0;
        chk("err_cleared", bus.err, 1'b0);

        // reset in WAIT discards the block and the channel keys
        bus.req_valid = 2'b01; bus.req_data0 = P0; core_lat = 0;
        cnt = 0;
        do begin step(); cnt++; end while (!last_en && cnt < 20);
        bus.req_valid = 2'b00;
        step(); step();
        reset_dut();
        txn(1'b0, P0, 3, gs, gct, gch);
        chk("postrst_strobe", gs, 1'b1);
        chk("postrst_ct", gct, f_enc(128'h0, P0));

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.req_valid = 2'($urandom);
            bus.req_data0 = {$urandom, $urandom, $urandom, $urandom};
            bus.req_data1 = ($urandom_range(0, 3) == 0) ? P1 : {$urandom, $urandom, $urandom, $urandom};
            bus.key_wr = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            bus.key_in0 = ($urandom_range(0, 1) == 0) ? K0 : {$urandom, $urandom, $urandom, $urandom};
            bus.key_in1 = ($urandom_range(0, 1) == 0) ? K1 : {$urandom, $urandom, $urandom, $urandom};
            bus.res_ready = ($urandom_range(0, 3) != 0);
            bus.err_clr = ($urandom_range(0, 15) == 0);
            core_lat = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 9);
            stray = ($urandom_range(0, 7) == 0);
            step();
        end
        stray = 1'b0; bus.req_valid = 2'b00; bus.key_wr = 2'b00;
        bus.err_clr = 1'b0; bus.res_ready = 1'b1;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
